// File: rtl/osc_freq_monitor.sv
// ---------------------------------------------------------------------------
// osc_freq_monitor
//
// Measures the frequency of the on-chip oscillator (asynchronous to clk) by
// counting its rising edges over a fixed gate of GATE_CYCLES clk cycles. The
// gate is aligned to the first detected oscillator edge. Each measurement is
// checked against [MIN_COUNT, MAX_COUNT]. A missing oscillator is reported as
// dead after TIMEOUT_CYCLES cycles without an edge. Any out-of-range report
// sets a sticky fault that the delay-generation logic uses as an interlock.
//
// Ports
//   clk         system clock; the only clock in this block
//   rst         synchronous, active-high reset
//   osc_in      oscillator output, asynchronous, frequency < clk/4
//   start       one-cycle request to begin; ignored unless idle
//   continuous  sampled in REPORT: 1 = measure back-to-back, 0 = go idle
//   fault_clr   clears the sticky fault (a coincident setting report wins)
//   busy        high whenever a measurement is in progress
//   meas_valid  one-cycle pulse while the report outputs are freshly updated
//   freq_count  rising-edge count from the last gate
//   in_range    MIN_COUNT <= freq_count <= MAX_COUNT at the last report
//   osc_dead    last report was an ARM timeout
//   fault       sticky; set by any report with in_range = 0
// ---------------------------------------------------------------------------
module osc_freq_monitor #(
    parameter int GATE_CYCLES    = 1000,
    parameter int CNT_W          = 16,
    parameter int MIN_COUNT      = 45,
    parameter int MAX_COUNT      = 55,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    input  logic             continuous,
    input  logic             fault_clr,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] freq_count,
    output logic             in_range,
    output logic             osc_dead,
    output logic             fault
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_REPORT
    } state_t;

    state_t state;
    state_t state_next;

    logic             sync1, sync2, sync3;
    logic             osc_edge;
    logic [GATE_W-1:0] gate_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  edge_cnt_inc;
    logic              gate_last;
    logic              timeout_hit;
    logic              count_ok;

    // Two flops resolve metastability; the third holds the previous sample so
    // a rising edge shows up as a single-cycle pulse.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and the shift register does not collapse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= osc_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign osc_edge    = sync2 & ~sync3;
    assign gate_last   = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Saturating increment; this is also the final count on the last gate
    // cycle, so an edge landing there is included.
    assign edge_cnt_inc = (osc_edge && (edge_cnt != {CNT_W{1'b1}}))
                          ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign count_ok     = (edge_cnt_inc >= CNT_W'(MIN_COUNT)) &&
                          (edge_cnt_inc <= CNT_W'(MAX_COUNT));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    // NOTE: the default assignment ahead of the case keeps every path
    // assigned, so no latch is inferred for state_next.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (start) state_next = S_ARM;
            S_ARM: begin
                if (osc_edge)         state_next = S_MEASURE;
                else if (timeout_hit) state_next = S_REPORT;
            end
            S_MEASURE: if (gate_last) state_next = S_REPORT;
            S_REPORT:  state_next = continuous ? S_MEASURE : S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy       = (state != S_IDLE);
        meas_valid = (state == S_REPORT);
    end

    // Counters and report registers. Report values are loaded on the edge
    // that enters REPORT so they are already valid while meas_valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt   <= '0;
            to_cnt     <= '0;
            edge_cnt   <= '0;
            freq_count <= '0;
            in_range   <= 1'b0;
            osc_dead   <= 1'b0;
            fault      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: to_cnt <= '0;
                S_ARM: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    // The aligning edge starts the gate but is not counted.
                    if (osc_edge) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                    end else if (timeout_hit) begin
                        freq_count <= '0;
                        in_range   <= 1'b0;
                        osc_dead   <= 1'b1;
                    end
                end
                S_MEASURE: begin
                    gate_cnt <= gate_cnt + GATE_W'(1);
                    edge_cnt <= edge_cnt_inc;
                    if (gate_last) begin
                        freq_count <= edge_cnt_inc;
                        in_range   <= count_ok;
                        osc_dead   <= 1'b0;
                    end
                end
                S_REPORT: begin
                    // Edges during REPORT are dropped; counters restart for a
                    // possible back-to-back gate.
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                end
                default: ;
            endcase

            // Setting report takes priority over a coincident clear.
            if ((state == S_REPORT) && !in_range) begin
                fault <= 1'b1;
            end else if (fault_clr) begin
                fault <= 1'b0;
            end
        end
    end

endmodule

// File: doc/osc_freq_monitor.md
Name: osc_freq_monitor

Overview:
- Consumes the on-chip oscillator output (Gowin_OSC oscout, GW1N-9, nominal 2.5 MHz) as an asynchronous input in the system clock domain.
- Measures its frequency by counting rising edges over a fixed gate of system-clock cycles.
- Checks the count against limits and raises dead-oscillator and out-of-range flags.
- Sits beside the delay-generation logic, which must not start a delay sequence while a fault is flagged.

Parameters:
- GATE_CYCLES, 1000, gate length in clk cycles (>=2).
- CNT_W, 16, width of the edge counter and freq_count.
- MIN_COUNT, 45, lowest in-range edge count (inclusive).
- MAX_COUNT, 55, highest in-range edge count (inclusive).
- TIMEOUT_CYCLES, 64, clk cycles allowed in ARM before the oscillator is declared dead.

Ports:
- clk  input  1  system clock; the only clock in this block.
- rst  input  1  synchronous, active-high reset.
- osc_in  input  1  oscillator output; asynchronous to clk; frequency < clk/4.
- start  input  1  one-cycle request to begin; ignored unless in IDLE.
- continuous  input  1  sampled in REPORT: 1 = re-measure back-to-back, 0 = return to IDLE.
- fault_clr  input  1  clears the sticky fault.
- busy  output  1  high in every state except IDLE.
- meas_valid  output  1  one-cycle pulse when freq_count, in_range and osc_dead update.
- freq_count  output  CNT_W  rising-edge count from the last gate.
- in_range  output  1  MIN_COUNT <= freq_count <= MAX_COUNT at the last report.
- osc_dead  output  1  last report was an ARM timeout.
- fault  output  1  sticky; set by any report with in_range=0.

Behaviour:
- Reset: all outputs 0; state IDLE; synchronizer and internal counters 0. Reset in any state returns to IDLE on the next edge and abandons any partial count; no meas_valid is produced.
- Input path: 2-flop synchronizer on osc_in, then a third flop for edge detection. edge = sync2 & ~sync3. A rising edge on osc_in gives edge high 3 clk edges later, ±1 cycle of metastability uncertainty.
- IDLE: busy=0. start=1 -> ARM; the timeout counter loads 0.
- ARM: waits for the first edge to align the gate.
  - edge=1 -> MEASURE. The gate counter and edge counter load 0; this aligning edge is not counted.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with no edge -> REPORT with a count of 0 and a dead indication.
- MEASURE: lasts exactly GATE_CYCLES clk cycles.
  - Each cycle with edge=1 increments the edge counter, saturating at 2^CNT_W-1.
  - On the last gate cycle (gate counter = GATE_CYCLES-1), an edge in that cycle is included; go to REPORT.
- REPORT: one cycle.
  - freq_count <= edge count; in_range per limits; osc_dead <= dead indication; meas_valid=1 for this cycle only.
  - continuous=1 -> MEASURE directly: the counters reload, no re-ARM, and the gate restarts on the next cycle.
  - continuous=0 -> IDLE.
- Timing: report period in continuous mode = GATE_CYCLES+1 clk cycles. An edge arriving during REPORT is not counted.
- fault:
  - Set in the cycle after any REPORT with in_range=0.
  - Cleared by fault_clr=1 in IDLE or any other state.
  - If a setting report and fault_clr coincide, set wins (fault=1).
- Outputs hold between reports.
- start while busy is ignored.
- Timeout report: freq_count=0, in_range=0, osc_dead=1.
- Comparisons are unsigned and at CNT_W width. A saturated count compares as 2^CNT_W-1.

Test Plan:
- Nominal: osc_in square wave, period 20 clk; start pulse. Required: meas_valid once; freq_count=50; in_range=1; osc_dead=0; fault=0; busy low the cycle after REPORT.
- Fast oscillator: period 16 clk. Required: freq_count 62 or 63; in_range=0; fault=1 after the report and held until fault_clr; a later nominal run leaves fault=1.
- Stuck oscillator: osc_in=0; start. Required: meas_valid exactly 64 cycles after entering ARM; freq_count=0; osc_dead=1; fault=1.
- Continuous mode: continuous=1, period 20. Required: meas_valid pulses spaced exactly 1001 clk apart, each with freq_count 50±1. Drop continuous -> IDLE after the next report.
- Clear collision: fast oscillator with fault_clr asserted in the REPORT cycle. Required: fault=1. fault_clr one cycle later -> fault=0.
- Reset mid-MEASURE: rst for 1 cycle at gate cycle 500. Required: all outputs 0; no meas_valid; state IDLE; a new start gives a clean 50-count report.
